// File: rtl/frame_swap_scheduler_if.sv
// frame_swap_scheduler_if: renderer write requests and the frame-buffer write port
interface frame_swap_scheduler_if #(parameter int ADDR_W = 15, parameter int PIX_W = 12);
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr, wr_addr;
  logic [PIX_W-1:0]  a_data, b_data, wr_data;
  logic              wr_en, wr_buf;
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_buf, wr_addr, wr_data
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_buf, wr_addr, wr_data
  );
endinterface

// File: rtl/frame_swap_scheduler.sv
// frame_swap_scheduler: double-buffer ownership with vblank-aligned swaps and round-robin renderer writes
module frame_swap_scheduler #(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 12,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank_start,
  input  logic                 frame_done,
  frame_swap_scheduler_if.slave bus,
  output logic                 display_buf,
  output logic                 draw_start,
  output logic [CNT_W-1:0]     missed_frames
);
  typedef enum logic [1:0] {START, DRAW, READY, SWAP} state_t;
  state_t            state_q, state_d;
  logic              grant_a, grant_b;
  logic              rr_last_q, rr_last_d;
  logic              display_buf_q, display_buf_d;
  logic              draw_start_q, draw_start_d;
  logic              wr_en_q, wr_en_d, wr_buf_q, wr_buf_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  missed_q, missed_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= START;
      rr_last_q     <= 1'b1;
      display_buf_q <= 1'b0;
      draw_start_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_buf_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      display_buf_q <= display_buf_d;
      draw_start_q  <= draw_start_d;
      wr_en_q       <= wr_en_d;
      wr_buf_q      <= wr_buf_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      missed_q      <= missed_d;
    end
  end
  always_comb begin
    state_d = (state_q == START || state_q == SWAP) ? DRAW :
              (state_q == DRAW && frame_done)       ? (vblank_start ? SWAP : READY) :
              (state_q == READY && vblank_start)    ? SWAP : state_q;
  end
  // rr_last = 1 means B was granted last, so A wins the next tie
  always_comb begin
    grant_a       = state_q == DRAW && bus.a_valid && (!bus.b_valid || rr_last_q);
    grant_b       = state_q == DRAW && bus.b_valid && (!bus.a_valid || !rr_last_q);
    rr_last_d     = grant_a ? 1'b0 : grant_b ? 1'b1 : rr_last_q;
    display_buf_d = state_q == SWAP ? ~display_buf_q : display_buf_q;
    draw_start_d  = state_q == START || state_q == SWAP;
    wr_en_d       = grant_a || grant_b;
    wr_buf_d      = wr_en_d ? ~display_buf_q : wr_buf_q;
    wr_addr_d     = grant_b ? bus.b_addr : grant_a ? bus.a_addr : wr_addr_q;
    wr_data_d     = grant_b ? bus.b_data : grant_a ? bus.a_data : wr_data_q;
    missed_d      = (state_q == DRAW && vblank_start && !frame_done && !(&missed_q)) ?
                    missed_q + CNT_W'(1) : missed_q;
  end
  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_buf     = wr_buf_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign display_buf    = display_buf_q;
  assign draw_start     = draw_start_q;
  assign missed_frames  = missed_q;
endmodule

// File: tb/tb_frame_swap_scheduler.sv
// tb_frame_swap_scheduler: per-cycle vector table plus a missed-frame saturation sequence
module tb_frame_swap_scheduler;
  logic clk = 1'b0, reset = 1'b1, vblank_start = 1'b0, frame_done = 1'b0;
  logic       display_buf, draw_start, s_display_buf, s_draw_start;
  logic [7:0] missed_frames;
  logic [1:0] s_missed_frames;
  int checks = 0, failures = 0;

  frame_swap_scheduler_if #(.ADDR_W(15), .PIX_W(12)) bus ();
  frame_swap_scheduler_if #(.ADDR_W(15), .PIX_W(12)) sbus ();

  frame_swap_scheduler #(.ADDR_W(15), .PIX_W(12), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .vblank_start(vblank_start), .frame_done(frame_done),
    .bus(bus.slave), .display_buf(display_buf), .draw_start(draw_start),
    .missed_frames(missed_frames));

  frame_swap_scheduler #(.ADDR_W(15), .PIX_W(12), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .vblank_start(vblank_start), .frame_done(frame_done),
    .bus(sbus.slave), .display_buf(s_display_buf), .draw_start(s_draw_start),
    .missed_frames(s_missed_frames));

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, vb, fd, av, bv;
    logic ar, br, we, wb, db, ds;
    logic [7:0] mf;
    logic src;
  } vec_t;
  vec_t tv [40];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //         rst vb fd av bv  ar br we wb db ds  mf    src
    tv[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[1]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 8'd0, 0};
    tv[2]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[3]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[4]  = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[5]  = '{0, 0, 0, 1, 1,  0, 1, 1, 1, 0, 0, 8'd0, 0};
    tv[6]  = '{0, 0, 0, 1, 1,  1, 0, 1, 1, 0, 0, 8'd0, 1};
    tv[7]  = '{0, 0, 0, 1, 1,  0, 1, 1, 1, 0, 0, 8'd0, 0};
    tv[8]  = '{0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 8'd0, 1};
    tv[9]  = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    for (int i = 10; i < 19; i++) tv[i] = '{0, 0, (i == 12), 1, 1,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[19] = '{0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[20] = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[21] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 1, 8'd0, 0};
    tv[22] = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 8'd0, 0};
    tv[23] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 8'd0, 0};
    tv[24] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 8'd1, 0};
    tv[25] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 8'd1, 0};
    tv[26] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 8'd2, 0};
    tv[27] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 8'd3, 0};
    tv[28] = '{0, 1, 1, 0, 1,  0, 1, 0, 0, 1, 0, 8'd3, 0};
    tv[29] = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 8'd3, 1};
    tv[30] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 8'd3, 0};
    tv[31] = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 8'd3, 0};
    tv[32] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd3, 0};
    tv[33] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd3, 0};
    tv[34] = '{0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 1, 8'd3, 0};
    tv[35] = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 8'd3, 0};
    tv[36] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[37] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 8'd0, 0};
    tv[38] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 0, 8'd0, 0};
    tv[39] = '{0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 8'd0, 0};

    {bus.a_valid, bus.b_valid, sbus.a_valid, sbus.b_valid} = '0;
    {bus.a_addr, bus.b_addr, sbus.a_addr, sbus.b_addr} = '0;
    {bus.a_data, bus.b_data, sbus.a_data, sbus.b_data} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_draw_start", -1, draw_start, 0);
    chk("reset_display_buf", -1, display_buf, 0);
    chk("reset_wr_en", -1, bus.wr_en, 0);
    chk("reset_missed", -1, missed_frames, 0);

    for (int i = 0; i < 40; i++) begin
      reset        = tv[i].rst;
      vblank_start = tv[i].vb;
      frame_done   = tv[i].fd;
      bus.a_valid  = tv[i].av;
      bus.b_valid  = tv[i].bv;
      bus.a_addr   = 15'(i);
      bus.a_data   = 12'ha00 + 12'(i);
      bus.b_addr   = 15'(100 + i);
      bus.b_data   = 12'hb00 + 12'(i);
      #1;
      chk("a_ready", i, bus.a_ready, tv[i].ar);
      chk("b_ready", i, bus.b_ready, tv[i].br);
      chk("wr_en", i, bus.wr_en, tv[i].we);
      chk("display_buf", i, display_buf, tv[i].db);
      chk("draw_start", i, draw_start, tv[i].ds);
      chk("missed_frames", i, missed_frames, tv[i].mf);
      if (tv[i].we) begin
        chk("wr_buf", i, bus.wr_buf, tv[i].wb);
        chk("wr_addr", i, bus.wr_addr, tv[i].src ? 100 + i - 1 : i - 1);
        chk("wr_data", i, bus.wr_data, tv[i].src ? 32'hb00 + i - 1 : 32'ha00 + i - 1);
      end
      @(posedge clk);
      #1;
    end

    {bus.a_valid, bus.b_valid, frame_done} = '0;
    for (int k = 1; k <= 5; k++) begin
      vblank_start = 1'b1;
      @(posedge clk);
      #1;
      vblank_start = 1'b0;
      chk("missed_wide", k, missed_frames, k);
      chk("missed_sat", k, s_missed_frames, k > 3 ? 3 : k);
      @(posedge clk);
      #1;
    end
    chk("display_after_misses", 0, display_buf, 0);
    chk("display_small_after_misses", 0, s_display_buf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
